// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants for the PWM output generator
package pwm_pkg;
  localparam int NUM_CH     = 16;
  localparam int PWM_CNT_W  = 8;
  localparam int PRESCALE_W = 16;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

  // Per-channel output: disabled wins, otherwise static high or the shared waveform.
  function automatic logic chan_level(input logic en_out, input logic en_pwm, input logic pwm_sig);
    return en_out & (~en_pwm | pwm_sig);
  endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - divides clk into one-cycle count-step ticks
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] pre_cnt;

  // With PRESCALE=1 LAST is zero, so pre_cnt sits at 0 and tick stays high.
  assign tick = (pre_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// rtl/pwm_generator.sv - 16-channel output driver with one shared, shadow-latched PWM waveform
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           en_reg_out_7_0,
  input  logic [7:0]           en_reg_out_15_8,
  input  logic [7:0]           en_reg_pwm_7_0,
  input  logic [7:0]           en_reg_pwm_15_8,
  input  logic [7:0]           pwm_duty_cycle,
  output logic [NUM_CH-1:0]    out,
  output logic                 period_start
);

  logic                  tick;
  logic                  wrap;
  logic                  pwm_sig;
  logic [PWM_CNT_W-1:0]  pwm_cnt;
  logic [PWM_CNT_W-1:0]  duty_sh;
  logic [NUM_CH-1:0]     en_out;
  logic [NUM_CH-1:0]     en_pwm;
  logic [NUM_CH-1:0]     out_d;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign wrap   = tick & (&pwm_cnt);

  // Full scale is special-cased so 0xFF means always high rather than 255/256.
  assign pwm_sig = (duty_sh == DUTY_FULL) | (pwm_cnt < duty_sh);

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      out_d[i] = chan_level(en_out[i], en_pwm[i], pwm_sig);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + PWM_CNT_W'(1);
    end
  end

  // Duty is only sampled at the wrap so a period in progress never changes shape.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh <= '0;
    end else if (wrap) begin
      duty_sh <= pwm_duty_cycle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= out_d;
      period_start <= wrap;
    end
  end

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Downstream consumer of the SPI register file: takes the five configuration bytes written over SPI (output enables, PWM enables, duty cycle) and drives the 16 chip outputs. Each output is forced low, forced high, or driven by one shared PWM waveform. An 8-bit period counter is clocked by a prescaler, and the duty cycle is shadow-latched at period boundaries so SPI writes never glitch a period in progress.

## Interface
Parameters:
- `PRESCALE`, default 13. Number of `clk` cycles per PWM count step; legal range 1..65535. At 10 MHz this gives about 3.0 kHz PWM.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en_reg_out_7_0`  in  8  output enable, channels 7..0.
- `en_reg_out_15_8`  in  8  output enable, channels 15..8.
- `en_reg_pwm_7_0`  in  8  PWM select, channels 7..0.
- `en_reg_pwm_15_8`  in  8  PWM select, channels 15..8.
- `pwm_duty_cycle`  in  8  requested duty; 0x00 = 0 %, 0xFF = 100 %.
- `out`  out  16  registered channel outputs.
- `period_start`  out  1  one-cycle pulse marking the first cycle of each PWM period.

## Operation
- Prescaler: `pre_cnt` counts 0..PRESCALE-1 and wraps. `tick` = (`pre_cnt` == PRESCALE-1). With PRESCALE=1, `tick` is constantly 1.
- Period counter: 8-bit `pwm_cnt` increments on `tick` and wraps from 255 to 0 (modulo 256, no saturation).
- Shadow duty: `duty_sh` loads `pwm_duty_cycle` on the wrap event only (`tick` and `pwm_cnt`==255). Writes mid-period take effect at the next period.
- Waveform: `pwm_sig` = (`duty_sh`==8'hFF) | (`pwm_cnt` < `duty_sh`), unsigned compare.
  - 0x00 gives constant low.
  - 0xFF gives constant high (special-cased, not 255/256).
  - Otherwise high for `duty_sh` × PRESCALE cycles per period.
- Channel i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise concatenated:
  - en_out[i]=0: `out[i]` = 0, regardless of en_pwm.
  - en_out[i]=1 and en_pwm[i]=0: `out[i]` = 1.
  - en_out[i]=1 and en_pwm[i]=1: `out[i]` = `pwm_sig`.
- All channels share one phase; there is no per-channel duty.
- `period_start` is a registered pulse, high for the one cycle in which `pwm_cnt`==0 after a wrap.

## Timing
- Reset values: `out`=16'h0000, `period_start`=0, `pre_cnt`=0, `pwm_cnt`=0, `duty_sh`=0.
- The first period after reset is therefore all-low on PWM channels. Static-high channels go high one cycle after their enables are set.
- Period length = 256 × PRESCALE `clk` cycles exactly. With PRESCALE=13 that is 3328 cycles.
- Enable change to `out`: 1 `clk` latency (output register).
- Duty change to `out`: takes effect at the start of the next period, plus the 1-cycle output register.
- Duty change and wrap in the same cycle: the new value is captured and applies to the starting period.
- Enable change mid-period: applies immediately, with 1-cycle latency. The PWM phase is not restarted.
- Reset asserted mid-period: all state clears asynchronously and `out` drops to 0 at once. The counter restarts from 0 on release.
- Inputs are already in the `clk` domain (registered by the SPI block), so no synchronisers are needed.

## Structure
- Shared package `pwm_pkg`:
  - `NUM_CH`=16
  - `PWM_CNT_W`=8
  - `DUTY_FULL`=8'hFF
  - `PRESCALE_W`=16
- One sub-module: `pwm_prescaler`, parameterised by PRESCALE. It owns `pre_cnt` and emits `tick`.
- Top level holds `pwm_cnt`, `duty_sh`, the compare, the per-channel mux and the output register.

## Test plan
- Reset: hold `rst_n`=0 with all enables 0xFF and duty 0x80 → `out`=0, `period_start`=0. Release; the first period is low on all channels; from the second period, `out` is high for 128×13=1664 cycles per 3328-cycle period.
- Static modes, duty=0x40: en_out=16'h00FF, en_pwm=16'h000F → ch15..8 = 0, ch7..4 = 1 constantly, ch3..0 high 832 of 3328 cycles.
- Boundaries, all channels in PWM mode: duty=0x00 → `out`=0 for a full period; duty=0xFF → `out`=16'hFFFF with no low cycle; duty=0x01 → high exactly 13 cycles per period.
- Glitch-free update: change duty 0x80→0x20 at `pwm_cnt`=50 → current period keeps 1664 high cycles, next period has 416. Also change duty exactly on the wrap cycle → new value applies immediately.
- Period marker: `period_start` pulses every 3328 cycles, coincident with the `pwm_sig` rising edge when duty > 0. With PRESCALE=1, the pulse comes every 256 cycles.
- Mid-operation reset: assert `rst_n` at `pwm_cnt`=200 → `out` goes to 0 asynchronously. After release, a full 3328-cycle period passes before the first `period_start`.
